// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and defaults for the FIFO write-port arbiter slice.
//   arb_state_e    : arbiter FSM states (idle / packet locked to an owner)
//   *_DEF          : default widths used by fifo_wr_arbiter and its interface
//   rr_next()      : round-robin pointer advance with modulo wrap
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 16;

  // Index following idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshakes and the FIFO write port seen by the arbiter.
//   req_valid/req_last/req_data/req_ready : per-requester beat handshake
//   fifo_wr_en/fifo_wr_data/fifo_full     : FIFO write side (fifoIf writer)
//   grant_id/busy                         : arbitration status
// Modports:
//   master : the arbiter (drives ready, FIFO write, status)
//   slave  : the environment (requesters + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic [IW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational rotate-priority finder: returns the first asserted request
// scanning ptr, ptr+1, ... with wrap at N. Reusable by any round-robin arbiter.
//   req   in  N   : request vector
//   ptr   in  IW  : highest-priority index this cycle (must be < N)
//   found out 1   : at least one request asserted
//   idx   out IW  : winning index, 0 when nothing is requested
// -----------------------------------------------------------------------------
module rr_select #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-level round-robin arbiter sharing one FIFO write port among NUM_REQ
// requesters. A winner owns the FIFO until its last beat is accepted, so
// packets never interleave. All datapaths are combinational (no output regs).
// Ports:
//   clk        in   : clock, all state on posedge
//   rst        in   : asynchronous active-low reset; forces ready/wr_en/
//                     busy/grant_id to 0 while low
//   bus        if   : fifo_wr_arbiter_if.master (requesters + FIFO + status)
//   stats_clr  in   : synchronous clear of packet counters   (stats build)
//   pkt_cnt    out  : saturating completed-packet counters   (stats build)
// Build option:
//   FIFO_WR_ARB_STATS_EN : adds stats_clr/pkt_cnt and per-requester counters.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                         stats_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0] pkt_cnt,
`endif
  fifo_wr_arbiter_if.master            bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;

  logic                  cand_found;
  logic [IW-1:0]         cand_idx;
  logic [IW-1:0]         sel;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    rr_ptr_d          = rr_ptr_q;
    owner_valid       = 1'b0;
    sel_last          = 1'b0;
    sel_data          = '0;
    bus.req_ready     = '0;

    sel = (state_q == ARB_LOCKED) ? owner_q : cand_idx;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        owner_valid = bus.req_valid[i];
        sel_last    = bus.req_last[i];
        sel_data    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // In IDLE the finder already tells us whether anyone is requesting.
    sel_valid = (state_q == ARB_LOCKED) ? owner_valid : cand_found;
    // Gating with rst keeps every handshake output low during reset.
    accept    = rst && sel_valid && !bus.fifo_full;

    if (accept) begin
      if (sel_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = IW'(rr_next(int'(sel), NUM_REQ));
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCKED;
        owner_d = sel;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (sel == IW'(i));
    end
    bus.fifo_wr_en   = accept;
    bus.fifo_wr_data = sel_data;
    bus.busy         = rst && (state_q == ARB_LOCKED);
    bus.grant_id     = rst ? sel : '0;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Completed-packet counters: count accepted last beats, saturate at all-ones,
  // and let a clear win over a same-cycle increment.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (stats_clr) begin
        cnt_q <= '0;
      end else if (accept && sel_last && (sel == IW'(g)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule
